// File: rtl/blackjack_cmd_pkg.sv
// -----------------------------------------------------------------------------
// blackjack_cmd_pkg
// Shared definitions for the blackjack input front end: command codes, the
// command code width and the layout of one command queue entry.
// No ports (package).
// -----------------------------------------------------------------------------
package blackjack_cmd_pkg;

   localparam int CMD_CODE_W = 2;

   localparam logic [CMD_CODE_W-1:0] CMD_NEXT   = 2'd0;
   localparam logic [CMD_CODE_W-1:0] CMD_HIT    = 2'd1;
   localparam logic [CMD_CODE_W-1:0] CMD_STAND  = 2'd2;
   localparam logic [CMD_CODE_W-1:0] CMD_DOUBLE = 2'd3;

   // One queued command: which button, the bet switches and the split switch
   // as they stood in the cycle the press was recognised.
   typedef struct packed {
      logic [CMD_CODE_W-1:0] code;
      logic [3:0]            bet;
      logic                  split;
   } cmd_entry_t;

   localparam int CMD_ENTRY_W = $bits(cmd_entry_t);

endpackage

// File: rtl/debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
// Two-flop synchroniser followed by a counting debouncer for one raw button.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-low reset
//   raw    in   asynchronous raw button level
//   level  out  debounced level (comes out of reset as 1 = "pressed", so a
//               button held through reset never looks like a fresh press)
// -----------------------------------------------------------------------------
module debounce_filter #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync_meta;
   logic             sync_q;
   logic [CNT_W-1:0] count;

   // The synchroniser pair brings the raw level into the clock domain. The
   // counter then runs only while the synced level disagrees with the
   // debounced one; any agreement clears it, so a glitch has to stay put for
   // DEBOUNCE_CYCLES consecutive cycles before the debounced level follows.
   // The level flips on the cycle the counter would reach DEBOUNCE_CYCLES.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
         count     <= '0;
         level     <= 1'b1;
      end else begin
         sync_meta <= raw;
         sync_q    <= sync_meta;
         if (sync_q == level) begin
            count <= '0;
         end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync_q;
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_command_encoder.sv
// -----------------------------------------------------------------------------
// button_command_encoder
// Turns the raw Basys 3 play buttons and bet/split switches into queued game
// commands handed out over a valid/ready handshake.
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   next, hit, stand, double      raw play buttons
//   split, bet_8..bet_1           raw switches (synchronised, not debounced)
//   cmd_ready                     consumer takes the head entry this cycle
//   cmd_valid                     head entry valid
//   cmd_code, cmd_bet, cmd_split  head entry contents (registered)
//   fifo_count                    queue occupancy
//   overflow                      sticky: a command was dropped on a full queue
//   collision                     sticky: several presses landed in one cycle
// -----------------------------------------------------------------------------
module button_command_encoder
   import blackjack_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          next,
   input  logic                          hit,
   input  logic                          stand,
   input  logic                          double,
   input  logic                          split,
   input  logic                          bet_8,
   input  logic                          bet_4,
   input  logic                          bet_2,
   input  logic                          bet_1,
   input  logic                          cmd_ready,
   output logic                          cmd_valid,
   output logic [1:0]                    cmd_code,
   output logic [3:0]                    cmd_bet,
   output logic                          cmd_split,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          collision
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [3:0]       btn_raw;
   logic [3:0]       level;
   logic [3:0]       level_q;
   logic [3:0]       press_q;
   logic [4:0]       sw_meta;
   logic [4:0]       sw_q;

   cmd_entry_t       new_entry;
   logic             push;
   logic             multi_press;

   cmd_entry_t       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_n;
   logic [CNT_W-1:0] count_n;
   logic             pop;
   logic             accept;
   logic             drop;
   cmd_entry_t       head_n;

   // Bit order is also the priority order: bit 0 (NEXT) wins.
   assign btn_raw = {double, stand, hit, next};

   for (genvar i = 0; i < 4; i++) begin : g_btn
      debounce_filter #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .raw   (btn_raw[i]),
         .level (level[i])
      );
   end

   // Switches only need synchronising. The press detector remembers the
   // previous debounced levels and registers a one-cycle pulse on each 0->1
   // transition; previous levels start at 1 to match the debouncers, so
   // nothing fires straight out of reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sw_meta <= '0;
         sw_q    <= '0;
         level_q <= 4'hF;
         press_q <= '0;
      end else begin
         sw_meta <= {split, bet_8, bet_4, bet_2, bet_1};
         sw_q    <= sw_meta;
         level_q <= level;
         press_q <= level & ~level_q;
      end
   end

   // Priority encode the press pulses into a single command tagged with the
   // switch snapshot of this cycle. Losing presses are simply discarded and
   // only show up through the collision flag.
   always_comb begin
      new_entry       = '0;
      new_entry.bet   = sw_q[3:0];
      new_entry.split = sw_q[4];
      push            = |press_q;
      multi_press     = ($countones(press_q) > 1);
      if (press_q[0]) begin
         new_entry.code = CMD_NEXT;
      end else if (press_q[1]) begin
         new_entry.code = CMD_HIT;
      end else if (press_q[2]) begin
         new_entry.code = CMD_STAND;
      end else begin
         new_entry.code = CMD_DOUBLE;
      end
   end

   // Queue bookkeeping for this cycle. A full queue can still take a command
   // when the head leaves in the same cycle. head_n is what the output stage
   // should show next; the only time the head is the entry being written now
   // is when the queue would otherwise hold nothing, which is exactly when
   // the write slot equals the next read slot.
   always_comb begin
      pop      = cmd_valid && cmd_ready;
      accept   = push && ((fifo_count != CNT_W'(FIFO_DEPTH)) || pop);
      drop     = push && !accept;
      count_n  = fifo_count + CNT_W'(accept) - CNT_W'(pop);
      rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
      if (accept && (wr_ptr == rd_ptr_n)) begin
         head_n = new_entry;
      end else begin
         head_n = mem[rd_ptr_n];
      end
   end

   // Queue storage has no reset; nothing is read from a slot before it has
   // been written, because cmd_valid is driven from the occupancy count.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= new_entry;
      end
   end

   // Pointers, occupancy, sticky flags and the registered head. The head data
   // only reloads while something is queued, so after the last pop it keeps
   // showing the final command it handed out.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         cmd_valid  <= 1'b0;
         cmd_code   <= '0;
         cmd_bet    <= '0;
         cmd_split  <= 1'b0;
         overflow   <= 1'b0;
         collision  <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         rd_ptr     <= rd_ptr_n;
         fifo_count <= count_n;
         cmd_valid  <= (count_n != '0);
         if (count_n != '0) begin
            cmd_code  <= head_n.code;
            cmd_bet   <= head_n.bet;
            cmd_split <= head_n.split;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         if (multi_press) begin
            collision <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_button_command_encoder.sv
// -----------------------------------------------------------------------------
// tb_button_command_encoder
// Self-checking bench for button_command_encoder with a short debounce window.
// Expected commands are queued when a press is driven and compared when the
// DUT hands a command over.
// -----------------------------------------------------------------------------
module tb_button_command_encoder;

   localparam int DEB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       next = 1'b0;
   logic       hit = 1'b0;
   logic       stand = 1'b0;
   logic       double = 1'b0;
   logic       split = 1'b0;
   logic       bet_8 = 1'b0;
   logic       bet_4 = 1'b0;
   logic       bet_2 = 1'b0;
   logic       bet_1 = 1'b0;
   logic       cmd_ready = 1'b1;
   logic       cmd_valid;
   logic [1:0] cmd_code;
   logic [3:0] cmd_bet;
   logic       cmd_split;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       collision;

   int         checks_total = 0;
   int         checks_passed = 0;
   int         edge_cnt = 0;
   int         valid_cycles = 0;
   int         max_count = 0;
   logic [6:0] exp_q [$];

   button_command_encoder #(
      .DEBOUNCE_CYCLES (DEB),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .next       (next),
      .hit        (hit),
      .stand      (stand),
      .double     (double),
      .split      (split),
      .bet_8      (bet_8),
      .bet_4      (bet_4),
      .bet_2      (bet_2),
      .bet_1      (bet_1),
      .cmd_ready  (cmd_ready),
      .cmd_valid  (cmd_valid),
      .cmd_code   (cmd_code),
      .cmd_bet    (cmd_bet),
      .cmd_split  (cmd_split),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .collision  (collision)
   );

   // 100 MHz clock plus an edge index so latencies can be measured in edges.
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks_total++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end else begin
         checks_passed++;
      end
   endtask

   // Reference encoding of a command from the bench's own switch settings.
   function automatic logic [6:0] expectedEntry(input logic [1:0] code);
      int bet_val;
      bet_val = 8 * int'(bet_8) + 4 * int'(bet_4) + 2 * int'(bet_2) + int'(bet_1);
      return {code, 4'(bet_val), split};
   endfunction

   function automatic logic [3:0] buttonOf(input logic [1:0] code);
      logic [3:0] b;
      b = 4'b0001 << code;
      return b;
   endfunction

   // Called in the drive phase (just after a rising edge): hold the buttons
   // for 'hold' cycles, release them and idle for 'gap' cycles.
   task automatic applyStimulus(input logic [3:0] btns, input int hold, input int gap);
      {double, stand, hit, next} = btns;
      repeat (hold) @(posedge clk);
      #1 {double, stand, hit, next} = 4'b0000;
      repeat (gap) @(posedge clk);
      #1;
   endtask

   // Press a button now and measure how many edges pass until cmd_valid.
   task automatic pressAndTime(input string tag, input logic [3:0] btns);
      int start;
      int lat;
      bit seen;
      start = edge_cnt;
      {double, stand, hit, next} = btns;
      seen = 1'b0;
      lat = -1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (cmd_valid) begin
            seen = 1'b1;
            lat = edge_cnt - start;
         end
      end
      checkOutput(tag, lat, DEB + 4);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every handed-over command must match the oldest
   // expected one. Also tracks valid cycles and peak occupancy.
   always @(negedge clk) begin
      logic [6:0] exp_e;
      if (cmd_valid) valid_cycles++;
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      if (reset && cmd_valid && cmd_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_cmd", 1, 0);
         end else begin
            exp_e = exp_q.pop_front();
            checkOutput("cmd_code", int'(cmd_code), int'(exp_e[6:5]));
            checkOutput("cmd_bet", int'(cmd_bet), int'(exp_e[4:1]));
            checkOutput("cmd_split", int'(cmd_split), int'(exp_e[0]));
         end
      end
   end

   initial begin
      int v0;
      logic [1:0] codes [5];
      codes = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_valid", int'(cmd_valid), 0);
      checkOutput("rst_count", int'(fifo_count), 0);
      checkOutput("rst_overflow", int'(overflow), 0);
      checkOutput("rst_collision", int'(collision), 0);
      checkOutput("rst_code", int'(cmd_code), 0);
      checkOutput("rst_bet", int'(cmd_bet), 0);
      checkOutput("rst_split", int'(cmd_split), 0);
      reset = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("idle_no_cmd", valid_cycles, 0);

      // 1: single hit press, latency, exactly one command while held.
      v0 = valid_cycles;
      exp_q.push_back(expectedEntry(2'd1));
      pressAndTime("t1_latency", 4'b0010);
      repeat (11) @(posedge clk);
      #1 hit = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("t1_valid_cycles", valid_cycles - v0, 1);
      checkOutput("t1_queue_empty", exp_q.size(), 0);

      // 2: short glitches never get through.
      v0 = valid_cycles;
      max_count = 0;
      for (int i = 0; i < 3; i++) applyStimulus(4'b0010, 2, 2);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("t2_valid_cycles", valid_cycles - v0, 0);
      checkOutput("t2_max_count", max_count, 0);

      // 3: switch snapshot travels with the command.
      {bet_8, bet_4, bet_2, bet_1} = 4'b1011;
      split = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      v0 = valid_cycles;
      exp_q.push_back(expectedEntry(2'd0));
      applyStimulus(4'b0001, 10, 15);
      checkOutput("t3_valid_cycles", valid_cycles - v0, 1);
      checkOutput("t3_queue_empty", exp_q.size(), 0);

      // 4: stall the consumer, fill the queue, overflow, then drain.
      {bet_8, bet_4, bet_2, bet_1} = 4'b0101;
      split = 1'b0;
      cmd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back(expectedEntry(codes[i]));
         applyStimulus(buttonOf(codes[i]), 8, 10);
         checkOutput("t4_head_valid", int'(cmd_valid), 1);
         checkOutput("t4_head_code", int'(cmd_code), 1);
         checkOutput("t4_count", int'(fifo_count), (i < 4) ? i + 1 : 4);
         checkOutput("t4_overflow", int'(overflow), (i == 4) ? 1 : 0);
      end
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("t4_drain_valid", int'(cmd_valid), 1);
      end
      @(negedge clk);
      checkOutput("t4_drained", int'(cmd_valid), 0);
      checkOutput("t4_queue_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // 5: simultaneous presses, NEXT wins.
      max_count = 0;
      v0 = valid_cycles;
      checkOutput("t5_collision_before", int'(collision), 0);
      exp_q.push_back(expectedEntry(2'd0));
      applyStimulus(4'b0101, 10, 15);
      checkOutput("t5_collision", int'(collision), 1);
      checkOutput("t5_max_count", max_count, 1);
      checkOutput("t5_valid_cycles", valid_cycles - v0, 1);
      checkOutput("t5_overflow_sticky", int'(overflow), 1);

      // 6: button held through reset produces nothing until pressed again.
      double = 1'b1;
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      checkOutput("t6_overflow_cleared", int'(overflow), 0);
      checkOutput("t6_collision_cleared", int'(collision), 0);
      v0 = valid_cycles;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("t6_held_no_cmd", valid_cycles - v0, 0);
      double = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("t6_release_no_cmd", valid_cycles - v0, 0);
      exp_q.push_back(expectedEntry(2'd3));
      pressAndTime("t6_latency", 4'b1000);
      repeat (5) @(posedge clk);
      #1 double = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("t6_valid_cycles", valid_cycles - v0, 1);
      checkOutput("t6_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
